// File: rtl/uart_tx_serializer_if.sv
// Frame handshake between a transmit client and uart_tx_serializer.
// Latency: none; this is a bundle of wires.
// Backpressure: client holds tx_start until it sees tx_ready; no skid.
// Signals: tx_start/tx_data from client, tx_ready/tx_done back from the serializer.
interface uart_tx_serializer_if;
  logic       tx_start;  // request to send, taken only while tx_ready=1
  logic [7:0] tx_data;   // payload, sampled in the accept cycle
  logic       tx_ready;  // serializer idle, can take a frame
  logic       tx_done;   // 1-cycle pulse when the last stop bit completes

  modport master (output tx_start, tx_data, input tx_ready, tx_done);
  modport slave  (input tx_start, tx_data, output tx_ready, tx_done);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit shifter: start bit, data LSB-first, optional parity, 1 or 2 stop bits.
// Latency: tx drops one clk after accept; each bit lasts one baud_tick period.
// Backpressure: tx_ready low for the whole frame; tx_start while busy is dropped.
// Ports: clk, rst (sync, active-high), host (tx_start/tx_data in, tx_ready/tx_done out),
//        baud_tick in (1x bit tick), baud_en out (enables the tick generator), tx out.
// Build option: define UART_TX_PARITY_EN to insert a parity bit (ParityOdd selects odd).
module uart_tx_serializer #(
  parameter int DataBits  = 8,
  parameter int StopBits  = 1,
  parameter int ParityOdd = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_serializer_if.slave   host,
  input  logic                  baud_tick,
  output logic                  baud_en,
  output logic                  tx
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic OddBit = (ParityOdd != 0);
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  // Parity sense is meaningless without the parity bit.
  logic unused_parity_odd;
  assign unused_parity_odd = (ParityOdd != 0);
`endif

  localparam logic [2:0] LastBit = 3'(DataBits - 1);

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic       stop2_q, stop2_d;   // first of two stop bits already sent
  logic       tx_q, tx_d;
  logic       rdy_q, rdy_d;
  logic       en_q, en_d;
  logic       done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  logic tick;
  logic accept;

  // A tick that arrives while the generator is disabled is stale.
  assign tick   = baud_tick & en_q;
  assign accept = host.tx_start & rdy_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    stop2_d = stop2_q;
    tx_d    = tx_q;
    rdy_d   = rdy_q;
    en_d    = en_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = host.tx_data;
          cnt_d   = 3'd0;
          stop2_d = 1'b0;
          tx_d    = 1'b0;
          rdy_d   = 1'b0;
          en_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = (^host.tx_data[DataBits-1:0]) ^ OddBit;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // Bit 1 of the current register becomes the next bit on the line.
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (StopBits == 2 && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            rdy_d   = 1'b1;
            en_d    = 1'b0;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= 8'd0;
      cnt_q   <= 3'd0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      en_q    <= en_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx            = tx_q;
  assign baud_en       = en_q;
  assign host.tx_ready = rdy_q;
  assign host.tx_done  = done_q;

endmodule
